// File: rtl/uart_tx_if.sv
// Host-side handshake bundle for the UART transmitter.
// The host drives uart_tx_en/uart_tx_data. The transmitter answers with uart_tx_busy.
interface uart_tx_if;
    logic       uart_tx_en;
    logic [7:0] uart_tx_data;
    logic       uart_tx_busy;

    // Host-side view: request a byte and watch busy.
    modport master (
        output uart_tx_en,
        output uart_tx_data,
        input  uart_tx_busy
    );

    // Transmitter-side view.
    modport slave (
        input  uart_tx_en,
        input  uart_tx_data,
        output uart_tx_busy
    );
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: 8 data bits LSB-first, optional odd/even parity, 1 or 2 stop bits.
// One byte is accepted per frame through the en/busy handshake.
// The serial line is driven from a register and idles high.
// CLK_HZ / BIT_RATE must be at least 2 so that every bit lasts at least two cycles.
module uart_tx #(
    parameter int BIT_RATE  = 9600,
    parameter int CLK_HZ    = 50_000_000,
    parameter int STOP_BITS = 1,
    parameter int PARITY    = 0
) (
    input  logic     clk,
    input  logic     resetn,
    uart_tx_if.slave tx_bus,
    output logic     uart_txd
);
    localparam int CYCLES_PER_BIT = CLK_HZ / BIT_RATE;
    localparam int CNT_W          = $clog2(CYCLES_PER_BIT) + 1;

    // An out-of-range format falls back to 8N1.
    localparam int STOP_N  = (STOP_BITS == 2) ? 2 : 1;
    localparam bit PAR_EN  = (PARITY == 1) || (PARITY == 2);
    localparam bit PAR_ODD = (PARITY == 1);

    localparam logic [CNT_W-1:0] LAST_CYCLE = CNT_W'(CYCLES_PER_BIT - 1);
    localparam logic [2:0]       LAST_STOP  = 3'(STOP_N - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t           state_q,  state_d;
    logic [CNT_W-1:0] cycle_q,  cycle_d;
    logic [2:0]       bit_q,    bit_d;
    logic [7:0]       shift_q,  shift_d;
    logic             parity_q, parity_d;
    logic             txd_q,    txd_d;
    logic             next_bit;

    assign next_bit            = (cycle_q == LAST_CYCLE);
    assign tx_bus.uart_tx_busy = (state_q != S_IDLE);
    assign uart_txd            = txd_q;

    // Register the state, the counters, the datapath and the line output. Reset drops any frame in flight.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q  <= S_IDLE;
            cycle_q  <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            parity_q <= 1'b0;
            txd_q    <= 1'b1;
        end else begin
            state_q  <= state_d;
            cycle_q  <= cycle_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            parity_q <= parity_d;
            txd_q    <= txd_d;
        end
    end

    // Next state: bit timing, the data shift, and stepping through the frame.
    always_comb begin
        state_d  = state_q;
        cycle_d  = next_bit ? '0 : cycle_q + CNT_W'(1);
        bit_d    = bit_q;
        shift_d  = shift_q;
        parity_d = parity_q;
        case (state_q)
            S_IDLE: begin
                cycle_d = '0;
                bit_d   = '0;
                if (tx_bus.uart_tx_en) begin
                    shift_d  = tx_bus.uart_tx_data;
                    parity_d = PAR_ODD ? ~(^tx_bus.uart_tx_data) : ^tx_bus.uart_tx_data;
                    state_d  = S_START;
                end
            end
            S_START: begin
                if (next_bit) begin
                    bit_d   = '0;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (next_bit) begin
                    shift_d = shift_q >> 1;
                    if (bit_q == 3'd7) begin
                        bit_d   = '0;
                        state_d = PAR_EN ? S_PARITY : S_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            S_PARITY: begin
                if (next_bit) begin
                    bit_d   = '0;
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                // bit_q counts the stop bits sent, so a 2-stop frame stays here for two bit periods.
                if (next_bit) begin
                    if (bit_q == LAST_STOP) begin
                        bit_d   = '0;
                        state_d = S_IDLE;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            default: begin
                cycle_d = '0;
                bit_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    // Line value for the state being entered. The register makes the start bit appear on the accepting edge.
    always_comb begin
        txd_d = 1'b1;
        case (state_d)
            S_START:  txd_d = 1'b0;
            S_DATA:   txd_d = shift_d[0];
            S_PARITY: txd_d = parity_d;
            default:  txd_d = 1'b1;
        endcase
    end
endmodule

// File: tb/tb_uart_tx.sv
// Testbench for uart_tx. Three transmitters run side by side: 8N1, 8E2 and 8O1, all at 10 clocks per bit.
// The stimulus queues each byte that is accepted.
// A monitor per channel rebuilds the required waveform from that byte and the frame format, then compares it cycle by cycle.
module tb_uart_tx;
    localparam int CLK_HZ   = 1_000_000;
    localparam int BIT_RATE = 100_000;
    localparam int CPB      = CLK_HZ / BIT_RATE;
    localparam int NCH      = 3;
    localparam int TMO      = 4000;
    localparam int PAR_OF [NCH] = '{0, 2, 1};
    localparam int STP_OF [NCH] = '{1, 2, 1};

    logic       clk    = 1'b0;
    logic       resetn = 1'b0;
    logic       en_drv   [NCH];
    logic [7:0] data_drv [NCH];
    logic       busy_mon [NCH];
    logic       txd_mon  [NCH];
    logic [7:0] exp_q    [NCH][$];
    int         errors = 0;
    int         checks = 0;

    always #5 clk = ~clk;

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
            uart_tx_if bus ();
            logic      txd;
            assign bus.uart_tx_en   = en_drv[gi];
            assign bus.uart_tx_data = data_drv[gi];
            assign busy_mon[gi]     = bus.uart_tx_busy;
            assign txd_mon[gi]      = txd;
            uart_tx #(
                .BIT_RATE  (BIT_RATE),
                .CLK_HZ    (CLK_HZ),
                .STOP_BITS (STP_OF[gi]),
                .PARITY    (PAR_OF[gi])
            ) dut (
                .clk      (clk),
                .resetn   (resetn),
                .tx_bus   (bus),
                .uart_txd (txd)
            );
        end
    endgenerate

    // Wait on falling edges until the channel reports idle.
    task automatic wait_idle(input int ch);
        int n;
        n = 0;
        @(negedge clk);
        while (busy_mon[ch] !== 1'b0 && n < TMO) begin
            @(negedge clk);
            n++;
        end
        if (n >= TMO) begin
            checks++;
            errors++;
            $display("FAIL ch%0d idle_timeout: busy=%b after %0d cycles, required 0", ch, busy_mon[ch], n);
        end
    endtask

    // Present one byte while the channel is idle and record it as the next expected frame.
    task automatic send(input int ch, input logic [7:0] d);
        wait_idle(ch);
        en_drv[ch]   = 1'b1;
        data_drv[ch] = d;
        exp_q[ch].push_back(d);
        @(posedge clk);
        #1;
        en_drv[ch]   = 1'b0;
        data_drv[ch] = 8'($urandom);
    endtask

    // Pulse en during a frame. The transmitter must ignore it, so nothing is queued.
    task automatic spurious(input int ch, input logic [7:0] d);
        @(negedge clk);
        en_drv[ch]   = 1'b1;
        data_drv[ch] = d;
        @(posedge clk);
        #1;
        en_drv[ch]   = 1'b0;
        data_drv[ch] = 8'($urandom);
    endtask

    // Hold en high across two frames. Busy must drop for exactly one cycle between them.
    task automatic back_to_back(input int ch, input logic [7:0] d0, input logic [7:0] d1);
        int n;
        int low;
        wait_idle(ch);
        en_drv[ch]   = 1'b1;
        data_drv[ch] = d0;
        exp_q[ch].push_back(d0);
        @(posedge clk);
        #1;
        data_drv[ch] = d1;
        exp_q[ch].push_back(d1);
        n = 0;
        @(negedge clk);
        while (busy_mon[ch] !== 1'b0 && n < TMO) begin
            @(negedge clk);
            n++;
        end
        low = 0;
        while (busy_mon[ch] === 1'b0 && low < TMO) begin
            low++;
            @(negedge clk);
        end
        en_drv[ch]   = 1'b0;
        data_drv[ch] = 8'($urandom);
        checks++;
        if (low != 1) begin
            errors++;
            $display("FAIL ch%0d b2b_gap: busy low for %0d cycles, required 1", ch, low);
        end
    endtask

    // Full stimulus for one channel: reset state, directed bytes, back-to-back frames, an ignored request, then random frames.
    task automatic run_channel(input int ch);
        @(negedge clk);
        checks++;
        if (txd_mon[ch] !== 1'b1 || busy_mon[ch] !== 1'b0) begin
            errors++;
            $display("FAIL ch%0d reset_state: txd=%b busy=%b, required txd=1 busy=0", ch, txd_mon[ch], busy_mon[ch]);
        end
        send(ch, 8'h55);
        send(ch, 8'h07);
        send(ch, 8'hA3);
        back_to_back(ch, 8'h00, 8'hFF);
        send(ch, 8'h96);
        repeat (25) @(negedge clk);
        spurious(ch, 8'h3C);
        repeat (6) begin
            repeat ($urandom_range(0, 12)) @(negedge clk);
            send(ch, 8'($urandom_range(0, 255)));
            if ($urandom_range(0, 2) == 0) begin
                repeat ($urandom_range(2, 80)) @(negedge clk);
                spurious(ch, 8'($urandom));
            end
        end
        wait_idle(ch);
        repeat (30 * CPB) @(negedge clk);
    endtask

    // Monitor: on each rising busy, take the expected byte and check every cycle of the frame plus the idle cycle after it.
    task automatic monitor(input int ch);
        bit         busy_prev;
        logic [7:0] b;
        bit         bits [$];
        int         bad;
        int         first;
        bit         aborted;
        logic       ftxd;
        logic       fbusy;
        busy_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                busy_prev = 1'b0;
            end else if (busy_mon[ch] === 1'b1 && !busy_prev) begin
                if (exp_q[ch].size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL ch%0d unexpected_frame: busy=1 with no byte accepted, required busy=0", ch);
                    busy_prev = 1'b1;
                end else begin
                    b = exp_q[ch].pop_front();
                    bits.delete();
                    bits.push_back(1'b0);
                    for (int i = 0; i < 8; i++) bits.push_back(b[i]);
                    if (PAR_OF[ch] == 2) bits.push_back(($countones(b) % 2) == 1);
                    if (PAR_OF[ch] == 1) bits.push_back(($countones(b) % 2) == 0);
                    for (int s = 0; s < STP_OF[ch]; s++) bits.push_back(1'b1);
                    bad     = 0;
                    first   = 0;
                    aborted = 1'b0;
                    ftxd    = 1'b0;
                    fbusy   = 1'b0;
                    for (int k = 0; k < bits.size() * CPB; k++) begin
                        if (k > 0) @(negedge clk);
                        if (!resetn) begin
                            aborted = 1'b1;
                            break;
                        end
                        if (busy_mon[ch] !== 1'b1 || txd_mon[ch] !== bits[k / CPB]) begin
                            if (bad == 0) begin
                                first = k;
                                ftxd  = txd_mon[ch];
                                fbusy = busy_mon[ch];
                            end
                            bad++;
                        end
                    end
                    if (!aborted) begin
                        checks++;
                        if (bad != 0) begin
                            errors++;
                            $display("FAIL ch%0d frame 0x%02h: %0d bad cycles, first at cycle %0d got txd=%b busy=%b, required txd=%b busy=1",
                                     ch, b, bad, first, ftxd, fbusy, bits[first / CPB]);
                        end
                        @(negedge clk);
                        if (resetn) begin
                            checks++;
                            if (busy_mon[ch] !== 1'b0 || txd_mon[ch] !== 1'b1) begin
                                errors++;
                                $display("FAIL ch%0d frame_end 0x%02h: busy=%b txd=%b, required busy=0 txd=1",
                                         ch, b, busy_mon[ch], txd_mon[ch]);
                            end
                        end
                    end
                    busy_prev = 1'b0;
                end
            end else begin
                busy_prev = busy_mon[ch];
            end
        end
    endtask

    // Start one monitor per channel.
    initial begin
        fork
            monitor(0);
            monitor(1);
            monitor(2);
        join_none
    end

    // Main sequence: reset, run the channels in parallel, reset one channel mid-frame, then check that no expected frame is left over.
    initial begin
        int bad;
        for (int i = 0; i < NCH; i++) begin
            en_drv[i]   = 1'b0;
            data_drv[i] = 8'h00;
        end
        resetn = 1'b0;
        repeat (5) @(posedge clk);
        #1 resetn = 1'b1;

        fork
            run_channel(0);
            run_channel(1);
            run_channel(2);
        join

        // Reset channel 0 at frame cycle 35, during data bit 2 of 0x00, where the line would otherwise be low.
        @(negedge clk);
        en_drv[0]   = 1'b1;
        data_drv[0] = 8'h00;
        exp_q[0].push_back(8'h00);
        @(posedge clk);
        #1 en_drv[0] = 1'b0;
        repeat (34) @(posedge clk);
        #1 resetn = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (txd_mon[0] !== 1'b1 || busy_mon[0] !== 1'b0) begin
            errors++;
            $display("FAIL mid_frame_reset: txd=%b busy=%b, required txd=1 busy=0", txd_mon[0], busy_mon[0]);
        end
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;
        bad = 0;
        repeat (300) begin
            @(negedge clk);
            for (int i = 0; i < NCH; i++) begin
                if (txd_mon[i] !== 1'b1 || busy_mon[i] !== 1'b0) bad++;
            end
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL post_reset_idle: %0d non-idle samples, required 0", bad);
        end

        for (int i = 0; i < NCH; i++) begin
            checks++;
            if (exp_q[i].size() != 0) begin
                errors++;
                $display("FAIL ch%0d missing_frames: %0d bytes never sent, required 0", i, exp_q[i].size());
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
